cmos_logic_unit_pipe: RTL and testbench

//  - Parametrised, pipelined successor of the single-bit all-gates block: WIDTH-bit bitwise logic unit.
//  - Opcode-selected NOT/NAND/NOR/AND/OR/XOR/XNOR/PASS, one operation per transaction.
//  - Per-bit datapath is built only from the team's switch-level cells: cmosnot, cmosnand, cmosnor, cmosxor.
//  - Two registered stages with valid/ready handshake, plus zero and parity result flags.
//  - Feeds register-file and test-pattern paths that need gate functions on buses at full throughput.

---
 rtl/cmos_logic_unit_pipe.sv | 158 +++++++++++++++
 tb/tb_cmos_logic_unit_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_logic_unit_pipe.sv
// Two-stage valid/ready pipelined WIDTH-bit logic unit whose per-bit datapath is
// composed solely of the cmosnot/cmosnand/cmosnor/cmosxor cells defined below.
module cmos_logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [2:0]       s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_parity;
  logic             s1_ready;
  logic             s2_ready;
  logic [WIDTH-1:0] logic_res;

  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cmos_logic_bit u_bit (
      .a  (s1_x[i]),
      .b  (s1_y[i]),
      .op (s1_op),
      .y  (logic_res[i])
    );
  end

  // Valid bits reset; data registers load only on a transfer so they hold under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b1;
      s2_parity <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
      end
      if (in_valid && s1_ready) begin
        s1_x  <= x;
        s1_y  <= y;
        s1_op <= op;
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
      end
      if (s1_valid && s2_ready) begin
        s2_result <= logic_res;
        s2_zero   <= ~|logic_res;
        s2_parity <= ^logic_res;
      end
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign zero      = s2_zero;
  assign parity    = s2_parity;

endmodule

// One result bit: all eight functions from the base cells, then an 8:1 mux tree
// indexed by op, itself built from NAND/NOT cells.
module cmos_logic_bit (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);

  logic not_a, nand_ab, nor_ab, xor_ab, and_ab, or_ab, xnor_ab;
  logic [3:0] lvl0;
  logic [1:0] lvl1;

  cmosnot  u_not  (.a(a),       .y(not_a));
  cmosnand u_nand (.a(a), .b(b), .y(nand_ab));
  cmosnor  u_nor  (.a(a), .b(b), .y(nor_ab));
  cmosxor  u_xor  (.a(a), .b(b), .y(xor_ab));
  cmosnot  u_and  (.a(nand_ab), .y(and_ab));
  cmosnot  u_or   (.a(nor_ab),  .y(or_ab));
  cmosnot  u_xnor (.a(xor_ab),  .y(xnor_ab));

  cmos_mux2 u_m00 (.d0(not_a),  .d1(nand_ab), .s(op[0]), .y(lvl0[0]));
  cmos_mux2 u_m01 (.d0(nor_ab), .d1(and_ab),  .s(op[0]), .y(lvl0[1]));
  cmos_mux2 u_m02 (.d0(or_ab),  .d1(xor_ab),  .s(op[0]), .y(lvl0[2]));
  cmos_mux2 u_m03 (.d0(xnor_ab), .d1(a),      .s(op[0]), .y(lvl0[3]));
  cmos_mux2 u_m10 (.d0(lvl0[0]), .d1(lvl0[1]), .s(op[1]), .y(lvl1[0]));
  cmos_mux2 u_m11 (.d0(lvl0[2]), .d1(lvl0[3]), .s(op[1]), .y(lvl1[1]));
  cmos_mux2 u_m20 (.d0(lvl1[0]), .d1(lvl1[1]), .s(op[2]), .y(y));

endmodule

// 2:1 mux as NAND-NAND with an inverted select.
module cmos_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);

  logic s_n, n0, n1;

  cmosnot  u_sn (.a(s), .y(s_n));
  cmosnand u_n0 (.a(d0), .b(s_n), .y(n0));
  cmosnand u_n1 (.a(d1), .b(s),   .y(n1));
  cmosnand u_ny (.a(n0), .b(n1),  .y(y));

endmodule

// Logic-level models of the switch-level cells, so the unit synthesises and lints.
module cmosnot (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module cmosnand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module cmosnor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a | b);
endmodule

module cmosxor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: tb/tb_cmos_logic_unit_pipe.sv
// Directed bench for cmos_logic_unit_pipe: reset, every opcode, zero flag,
// backpressure, back-to-back throughput and mid-flight reset.
module tb_cmos_logic_unit_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero;
  logic       parity;

  int vecCount = 0;
  int missCount = 0;
  int cycleCnt = 0;

  logic [7:0] outQ[$];
  int         outCycle[$];
  logic [7:0] expQ[$];

  cmos_logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .parity    (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Records every result that actually transfers out of the unit.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      outQ.push_back(result);
      outCycle.push_back(cycleCnt);
    end
  end

  function automatic logic [7:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] code);
    case (code)
      3'd0: refModel = ~a;
      3'd1: refModel = ~(a & b);
      3'd2: refModel = ~(a | b);
      3'd3: refModel = a & b;
      3'd4: refModel = a | b;
      3'd5: refModel = a ^ b;
      3'd6: refModel = ~(a ^ b);
      default: refModel = a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic driveEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  // One isolated transaction with latency and flag checks; out_ready held high.
  task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] code, input logic [7:0] expRes,
                               input logic expZero, input logic expPar);
    driveEdge();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    x  = a;
    y  = b;
    op = code;
    waitNeg();
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    driveEdge();
    in_valid = 1'b0;
    waitNeg();
    checkOutput({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    driveEdge();
    waitNeg();
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
    checkOutput({tag, "_zero"}, 32'(zero), 32'(expZero));
    checkOutput({tag, "_parity"}, 32'(parity), 32'(expPar));
  endtask

  logic [7:0] t2Exp[8] = '{8'h5A, 8'hDB, 8'h42, 8'h24, 8'hBD, 8'h99, 8'h66, 8'hA5};
  logic [7:0] t4X[4]   = '{8'hFF, 8'h30, 8'hFF, 8'h0F};
  logic [7:0] t4Y[4]   = '{8'h0F, 8'h03, 8'hAA, 8'hF0};
  logic [2:0] t4Op[4]  = '{3'd3, 3'd4, 3'd5, 3'd1};
  logic [7:0] t4Exp[4] = '{8'h0F, 8'h33, 8'h55, 8'hFF};

  initial begin
    int idx;
    logic rdy;

    // T1: reset held with a valid input pending
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    x = 8'h12;
    y = 8'h34;
    op = 3'd4;
    for (int i = 0; i < 2; i++) begin
      waitNeg();
      checkOutput("t1_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t1_result", 32'(result), 32'd0);
      checkOutput("t1_zero", 32'(zero), 32'd1);
      checkOutput("t1_parity", 32'(parity), 32'd0);
    end
    driveEdge();
    rst = 1'b0;
    in_valid = 1'b0;
    waitNeg();
    checkOutput("t1_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t1_no_accept0", 32'(out_valid), 32'd0);
    driveEdge();
    waitNeg();
    checkOutput("t1_no_accept1", 32'(out_valid), 32'd0);

    // T2: every opcode on A5/3C
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("t2_op%0d", i), 8'hA5, 8'h3C, 3'(i), t2Exp[i], 1'b0, 1'b0);
    end

    // T3: AND producing zero
    applyStimulus("t3_and_zero", 8'hF0, 8'h0F, 3'd3, 8'h00, 1'b1, 1'b0);

    // T4: backpressure with four queued operations
    driveEdge();
    outQ.delete();
    outCycle.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) driveEdge();
      in_valid = 1'b1;
      x  = t4X[idx];
      y  = t4Y[idx];
      op = t4Op[idx];
      waitNeg();
      rdy = in_ready;
      if (c >= 2) begin
        checkOutput($sformatf("t4_hold_valid%0d", c), 32'(out_valid), 32'd1);
        checkOutput($sformatf("t4_hold_result%0d", c), 32'(result), 32'(t4Exp[0]));
      end
      if (rdy) idx++;
    end
    checkOutput("t4_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("t4_accepts", 32'(idx), 32'd2);
    checkOutput("t4_none_out", 32'(outQ.size()), 32'd0);
    for (int k = 0; k < 20 && outQ.size() < 4; k++) begin
      driveEdge();
      out_ready = 1'b1;
      if (idx < 4) begin
        in_valid = 1'b1;
        x  = t4X[idx];
        y  = t4Y[idx];
        op = t4Op[idx];
      end else begin
        in_valid = 1'b0;
      end
      waitNeg();
      if (in_valid && in_ready) idx++;
    end
    driveEdge();
    in_valid = 1'b0;
    waitNeg();
    checkOutput("t4_count", 32'(outQ.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < outQ.size()) checkOutput($sformatf("t4_order%0d", i), 32'(outQ[i]), 32'(t4Exp[i]));
    end

    // T5: 16 back-to-back random operations
    outQ.delete();
    outCycle.delete();
    expQ.delete();
    for (int i = 0; i < 16; i++) begin
      driveEdge();
      in_valid = 1'b1;
      x  = 8'($urandom);
      y  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      expQ.push_back(refModel(x, y, op));
      waitNeg();
      checkOutput($sformatf("t5_in_ready%0d", i), 32'(in_ready), 32'd1);
    end
    driveEdge();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && outQ.size() < 16; k++) waitNeg();
    checkOutput("t5_count", 32'(outQ.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < outQ.size()) begin
        checkOutput($sformatf("t5_result%0d", i), 32'(outQ[i]), 32'(expQ[i]));
        checkOutput($sformatf("t5_cycle%0d", i), 32'(outCycle[i] - outCycle[0]), 32'(i));
      end
    end

    // T6: reset with two operations in flight
    driveEdge();
    outQ.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 8'h11;
    y = 8'h22;
    op = 3'd0;
    waitNeg();
    driveEdge();
    x = 8'h0F;
    op = 3'd4;
    waitNeg();
    driveEdge();
    rst = 1'b1;
    in_valid = 1'b0;
    waitNeg();
    checkOutput("t6_inflight", 32'(out_valid), 32'd1);
    driveEdge();
    rst = 1'b0;
    out_ready = 1'b1;
    waitNeg();
    checkOutput("t6_flushed", 32'(out_valid), 32'd0);
    checkOutput("t6_flushed_in_ready", 32'(in_ready), 32'd1);
    applyStimulus("t6_after", 8'hC3, 8'h81, 3'd5, 8'h42, 1'b0, 1'b0);
    driveEdge();
    waitNeg();
    checkOutput("t6_emitted", 32'(outQ.size()), 32'd1);
    if (outQ.size() > 0) checkOutput("t6_emitted_value", 32'(outQ[0]), 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
